// File: rtl/game_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer_if
//  Description : Player-move handshake, win-checker handshake and display bus
//                of the Connect-Four game sequencer.
//                slave  : view used by game_sequencer
//                master : view used by whatever drives moves/checker results
//  Signals     : start, move_valid, col_sel[2:0], check_done, check_win,
//                check_mask[41:0]           (master -> slave)
//                move_ready, move_reject, check_req, board_state[83:0],
//                winner_play[83:0], theres_a_winner, current_state[2:0]
//                                           (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_sequencer_if;

    logic        start;
    logic        move_valid;
    logic [2:0]  col_sel;
    logic        move_ready;
    logic        move_reject;
    logic        check_req;
    logic        check_done;
    logic        check_win;
    logic [41:0] check_mask;
    logic [83:0] board_state;
    logic [83:0] winner_play;
    logic        theres_a_winner;
    logic [2:0]  current_state;

    modport slave (
        input  start, move_valid, col_sel, check_done, check_win, check_mask,
        output move_ready, move_reject, check_req, board_state, winner_play,
               theres_a_winner, current_state
    );

    modport master (
        output start, move_valid, col_sel, check_done, check_win, check_mask,
        input  move_ready, move_reject, check_req, board_state, winner_play,
               theres_a_winner, current_state
    );

endinterface
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Turn sequencer for a 7-column x 6-row Connect-Four board.
//                Accepts column drops from the active player, places the
//                piece in the lowest free row, hands the board to an external
//                win checker and moves on to the next turn, a win or a draw.
//  Parameters  : TURN_CYCLES - turn timeout length in clk cycles
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - game_sequencer_if.slave (moves, checker, display)
//  Options     : define TURN_TIMER_EN to add the per-turn timeout that forces
//                a drop into the lowest-index non-full column.
//  Board       : 2 bits per cell at [(row*7+col)*2 +: 2], row 0 at the top;
//                00 empty, 01 player 1, 10 player 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer #(
    parameter int unsigned TURN_CYCLES = 500_000_000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    game_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_DROP  = 3'd2,
        S_CHECK = 3'd3,
        S_WIN   = 3'd4,
        S_DRAW  = 3'd5
    } state_t;

    localparam logic [5:0] c_ALL_MOVES = 6'd42;

    // A zero-length turn would fire the timeout on the same cycle WAIT is
    // entered, which the timer cannot express.
    if (TURN_CYCLES == 0) begin : g_bad_turn_cycles
        $error("game_sequencer: TURN_CYCLES must be at least 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q,  state_d;
    logic        turn_q,   turn_d;     // 0 = player 1, 1 = player 2
    logic [83:0] board_q,  board_d;
    logic [41:0] mask_q,   mask_d;
    logic [5:0]  count_q,  count_d;
    logic [2:0]  col_q,    col_d;
    logic        reject_q, reject_d;

    // ------------------------------------------------------------------
    // Board helpers
    // ------------------------------------------------------------------
    // Bit 7 stands for the out-of-range column 7 so that col_sel can index
    // this vector directly: an illegal column reads as "full".
    logic [7:0] w_col_full;
    logic       w_req_legal;
    logic [2:0] w_drop_row;

    always_comb begin
        w_col_full    = 8'd0;
        w_col_full[7] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            w_col_full[c] = (board_q[c*2 +: 2] != 2'b00);
        end
    end

    assign w_req_legal = ~w_col_full[bus.col_sel];

    // Highest-numbered empty row of the registered column; the column was
    // known to have space when it was accepted, so some row always matches.
    always_comb begin
        w_drop_row = 3'd5;
        for (int r = 0; r < 6; r++) begin
            if (board_q[(r*7 + int'(col_q))*2 +: 2] == 2'b00) begin
                w_drop_row = 3'(r);
            end
        end
    end

    // ------------------------------------------------------------------
    // Turn timer
    // ------------------------------------------------------------------
    logic       w_timeout;
    logic [2:0] w_auto_col;

`ifdef TURN_TIMER_EN
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TURN_CYCLES - 1);

    logic [31:0] timer_q, timer_d;
    logic        w_auto_ok;

    // Walk from the right so the lowest-index free column wins.
    always_comb begin
        w_auto_col = 3'd0;
        w_auto_ok  = 1'b0;
        for (int c = 6; c >= 0; c--) begin
            if (!w_col_full[c]) begin
                w_auto_col = 3'(c);
                w_auto_ok  = 1'b1;
            end
        end
    end

    assign w_timeout = (state_q == S_WAIT) && (timer_q == c_TIMEOUT_LAST) && w_auto_ok;

    // Counts while the FSM stays in WAIT; any other path (including the
    // entry into WAIT) restarts the count from zero.
    always_comb begin
        timer_d = '0;
        if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
            timer_d = timer_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign w_timeout  = 1'b0;
    assign w_auto_col = 3'd0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        turn_d   = turn_q;
        board_d  = board_q;
        mask_d   = mask_q;
        count_d  = count_q;
        col_d    = col_q;
        reject_d = 1'b0;

        case (state_q)
            S_IDLE, S_WIN, S_DRAW: begin
                if (bus.start) begin
                    board_d = '0;
                    mask_d  = '0;
                    count_d = '0;
                    turn_d  = 1'b0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // move_ready is high throughout WAIT, so move_valid alone
                // completes the handshake here.
                if (bus.move_valid && w_req_legal) begin
                    col_d   = bus.col_sel;
                    state_d = S_DROP;
                end else begin
                    reject_d = bus.move_valid;
                    if (w_timeout) begin
                        col_d   = w_auto_col;
                        state_d = S_DROP;
                    end
                end
            end

            S_DROP: begin
                board_d[(int'(w_drop_row)*7 + int'(col_q))*2 +: 2] =
                    turn_q ? 2'b10 : 2'b01;
                count_d = count_q + 6'd1;
                state_d = S_CHECK;
            end

            S_CHECK: begin
                if (bus.check_done) begin
                    // Win is tested first so a winning 42nd move is a win.
                    if (bus.check_win) begin
                        mask_d  = bus.check_mask;
                        state_d = S_WIN;
                    end else if (count_q == c_ALL_MOVES) begin
                        state_d = S_DRAW;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = S_WAIT;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            turn_q   <= 1'b0;
            board_q  <= '0;
            mask_q   <= '0;
            count_q  <= '0;
            col_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            board_q  <= board_d;
            mask_q   <= mask_d;
            count_q  <= count_d;
            col_q    <= col_d;
            reject_q <= reject_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded from registers, so they drop to 0 with reset)
    // ------------------------------------------------------------------
    logic [2:0] w_disp;

    always_comb begin
        w_disp = 3'd0;
        case (state_q)
            S_WAIT, S_DROP, S_CHECK: w_disp = turn_q ? 3'd2 : 3'd1;
            S_WIN:                   w_disp = 3'd3;
            S_DRAW:                  w_disp = 3'd4;
            default:                 w_disp = 3'd0;
        endcase
    end

    assign bus.move_ready      = (state_q == S_WAIT);
    assign bus.move_reject     = reject_q;
    assign bus.check_req       = (state_q == S_CHECK);
    assign bus.board_state     = board_q;
    assign bus.winner_play     = {42'd0, mask_q};
    assign bus.theres_a_winner = (state_q == S_WIN);
    assign bus.current_state   = w_disp;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_sequencer
//  Description : Self-checking bench for game_sequencer. A small board model
//                produces expected boards; expectations are queued when a
//                move is driven and compared when the DUT answers with either
//                move_reject or check_req. Build with TURN_TIMER_EN defined
//                to also exercise the turn timeout (TURN_CYCLES = 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

    localparam logic [41:0] WIN_MASK = 42'(4'hF) << 35;

    logic clk;
    logic rst_n;

    game_sequencer_if u_if ();

    game_sequencer #(.TURN_CYCLES(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_total = 0;
    int n_pass  = 0;

    function automatic void chk(input string name, input logic [83:0] act, input logic [83:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic void fail(input string name);
        n_total++;
        $display("FAIL %s: DUT event did not arrive within its cycle budget", name);
    endfunction

    // ------------------------------------------------------------------
    // Board model and scoreboard
    // ------------------------------------------------------------------
    logic [1:0]  mb [6][7];
    bit          m_turn;
    int          m_count;
    logic [41:0] m_mask;

    typedef struct {
        bit          is_reject;
        logic [83:0] board;
        logic [2:0]  cs;
    } exp_t;

    exp_t sb[$];

    function automatic logic [83:0] pack();
        logic [83:0] b = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                b[(r*7+c)*2 +: 2] = mb[r][c];
        return b;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                mb[r][c] = 2'b00;
        m_turn  = 1'b0;
        m_count = 0;
        m_mask  = '0;
    endfunction

    // Puts the model's expected drop result on the scoreboard.
    task automatic push_drop(input int col);
        exp_t e;
        int row = 5;
        while (mb[row][col] != 2'b00) row--;
        mb[row][col] = m_turn ? 2'b10 : 2'b01;
        m_count++;
        e.is_reject = 1'b0;
        e.board     = pack();
        e.cs        = m_turn ? 3'd2 : 3'd1;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!u_if.move_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!u_if.move_ready) fail("wait_move_ready");
    endtask

    // Waits for the DUT's answer to a move and compares it with the oldest
    // queued expectation.
    task automatic score();
        exp_t e;
        int n = 0;
        while (!(u_if.move_reject || u_if.check_req) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() == 0) begin
            fail("scoreboard_empty");
            return;
        end
        e = sb.pop_front();
        if (!(u_if.move_reject || u_if.check_req)) begin
            fail("move_response");
            return;
        end
        chk("answer_is_reject", 84'(u_if.move_reject), 84'(e.is_reject));
        chk("board_state",      u_if.board_state,      e.board);
        chk("current_state",    84'(u_if.current_state), 84'(e.cs));
    endtask

    task automatic finish_check(input bit win, input logic [41:0] mask, input int hold,
                                input logic [2:0] exp_cs);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("check_req_held", 84'(u_if.check_req), 84'(1'b1));
        end
        chk("ready_low_in_check", 84'(u_if.move_ready), 84'(1'b0));
        u_if.check_done = 1'b1;
        u_if.check_win  = win;
        u_if.check_mask = mask;
        @(negedge clk);
        u_if.check_done = 1'b0;
        u_if.check_win  = 1'b0;
        u_if.check_mask = '0;
        if (win) m_mask = mask;
        else if (m_count < 42) m_turn = ~m_turn;
        chk("state_after_check", 84'(u_if.current_state),   84'(exp_cs));
        chk("theres_a_winner",   84'(u_if.theres_a_winner), 84'(exp_cs == 3'd3));
        chk("winner_play",       u_if.winner_play,          84'(m_mask));
    endtask

    task automatic play(input int col, input bit win, input logic [41:0] mask,
                        input int hold, input logic [2:0] exp_cs);
        bit   legal = 1'b0;
        exp_t e;
        wait_ready();
        if (col <= 6) legal = (mb[0][col] == 2'b00);
        if (legal) begin
            push_drop(col);
        end else begin
            e.is_reject = 1'b1;
            e.board     = pack();
            e.cs        = m_turn ? 3'd2 : 3'd1;
            sb.push_back(e);
        end
        u_if.move_valid = 1'b1;
        u_if.col_sel    = 3'(col);
        @(negedge clk);
        u_if.move_valid = 1'b0;
        score();
        if (!legal) begin
            @(negedge clk);
            chk("reject_single_pulse", 84'(u_if.move_reject),   84'(1'b0));
            chk("state_after_reject",  84'(u_if.current_state), 84'(exp_cs));
            chk("ready_after_reject",  84'(u_if.move_ready),    84'(1'b1));
        end else begin
            finish_check(win, mask, hold, exp_cs);
        end
    endtask

    task automatic pulse_start();
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        int          col;
        bit          win;
        logic [41:0] mask;
        int          hold;
        logic [2:0]  exp_cs;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{3, 1'b0, 42'd0,    2, 3'd2};  // P1 col 3, checker slow
        vecs[1] = '{0, 1'b0, 42'd0,    0, 3'd1};
        vecs[2] = '{0, 1'b0, 42'd0,    0, 3'd2};
        vecs[3] = '{0, 1'b0, 42'd0,    0, 3'd1};
        vecs[4] = '{0, 1'b0, 42'd0,    0, 3'd2};
        vecs[5] = '{0, 1'b0, 42'd0,    0, 3'd1};
        vecs[6] = '{0, 1'b0, 42'd0,    0, 3'd2};  // col 0 now full
        vecs[7] = '{0, 1'b0, 42'd0,    0, 3'd2};  // full column
        vecs[8] = '{7, 1'b0, 42'd0,    0, 3'd2};  // out-of-range column
        vecs[9] = '{4, 1'b1, WIN_MASK, 0, 3'd3};  // checker reports a win

        u_if.start      = 1'b0;
        u_if.move_valid = 1'b0;
        u_if.col_sel    = 3'd0;
        u_if.check_done = 1'b0;
        u_if.check_win  = 1'b0;
        u_if.check_mask = '0;
        model_clear();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_current_state", 84'(u_if.current_state), 84'(0));
        chk("rst_board",         u_if.board_state,        84'(0));
        chk("rst_move_ready",    84'(u_if.move_ready),    84'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_state", 84'(u_if.current_state), 84'(0));

        // Table-driven game ending in a win
        pulse_start();
        model_clear();
        chk("start_to_p1", 84'(u_if.current_state), 84'(1));
        for (int i = 0; i < 10; i++) begin
            if (i == 1) begin
                pulse_start();
                chk("start_ignored_state", 84'(u_if.current_state), 84'(2));
                chk("start_ignored_board", u_if.board_state,        pack());
            end
            play(vecs[i].col, vecs[i].win, vecs[i].mask, vecs[i].hold, vecs[i].exp_cs);
        end
        chk("win_mask_exact", u_if.winner_play, 84'(WIN_MASK));

        // Restart from WIN
        pulse_start();
        model_clear();
        chk("restart_board",  u_if.board_state,        84'(0));
        chk("restart_state",  84'(u_if.current_state), 84'(1));
        chk("restart_winner", u_if.winner_play,        84'(0));

        // Fill the whole board without a win: the 42nd move draws
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                play(c, 1'b0, 42'd0, 0,
                     (c*6 + r == 41) ? 3'd4 : (m_turn ? 3'd1 : 3'd2));
            end
        end
        chk("draw_no_winner", 84'(u_if.theres_a_winner), 84'(0));

        // Reset while the checker request is pending
        pulse_start();
        model_clear();
        wait_ready();
        u_if.move_valid = 1'b1;
        u_if.col_sel    = 3'd2;
        @(negedge clk);
        u_if.move_valid = 1'b0;
        @(negedge clk);
        chk("in_check_req", 84'(u_if.check_req), 84'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_state",  84'(u_if.current_state),   84'(0));
        chk("async_rst_board",  u_if.board_state,          84'(0));
        chk("async_rst_req",    84'(u_if.check_req),       84'(0));
        chk("async_rst_ready",  84'(u_if.move_ready),      84'(0));
        chk("async_rst_reject", 84'(u_if.move_reject),     84'(0));
        chk("async_rst_win",    84'(u_if.theres_a_winner), 84'(0));
        chk("async_rst_mask",   u_if.winner_play,          84'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // IDLE ignores moves and checker results
        u_if.move_valid = 1'b1;
        u_if.col_sel    = 3'd0;
        u_if.check_done = 1'b1;
        u_if.check_win  = 1'b1;
        u_if.check_mask = WIN_MASK;
        repeat (2) @(negedge clk);
        u_if.move_valid = 1'b0;
        u_if.check_done = 1'b0;
        u_if.check_win  = 1'b0;
        u_if.check_mask = '0;
        chk("idle_ignore_state", 84'(u_if.current_state), 84'(0));
        chk("idle_ignore_board", u_if.board_state,        84'(0));
        chk("idle_ignore_mask",  u_if.winner_play,        84'(0));

`ifdef TURN_TIMER_EN
        // Turn timeout with column 0 full: P1 is forced into column 1
        begin
            int n = 0;
            pulse_start();
            model_clear();
            for (int i = 0; i < 6; i++) play(0, 1'b0, 42'd0, 0, m_turn ? 3'd1 : 3'd2);
            push_drop(1);
            while (u_if.move_ready && n < 64) begin
                n++;
                @(negedge clk);
            end
            chk("timeout_wait_cycles", 84'(n), 84'(16));
            score();
            chk("auto_drop_cell", 84'(u_if.board_state[(5*7+1)*2 +: 2]), 84'(2'b01));
            finish_check(1'b0, 42'd0, 0, 3'd2);
        end
`endif

        chk("scoreboard_drained", 84'(sb.size()), 84'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 500_000_000, turn-timeout length in clk cycles (10 s at 50 MHz).
REQ-002 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; asynchronous and active-low.
REQ-004 SHALL have port start  in  1  one-cycle pulse that begins a new game.
REQ-005 SHALL have port move_valid  in  1  column-drop request from the active player.
REQ-006 SHALL have port col_sel  in  3  requested column, 0 (leftmost) to 6.
REQ-007 SHALL have port move_ready  out  1  high only while waiting for a player move.
REQ-008 SHALL have port move_reject  out  1  one-cycle pulse when an accepted request is illegal.
REQ-009 SHALL have port check_req  out  1  request to the external win checker; held until check_done.
REQ-010 SHALL have port check_done  in  1  checker result valid, one cycle.
REQ-011 SHALL have port check_win  in  1  qualified by check_done; a line of four exists.
REQ-012 SHALL have port check_mask  in  42  qualified by check_done; winning cells, bit row*7+col.
REQ-013 SHALL have port board_state  out  84  2 bits per cell at [(row*7+col)*2 +: 2]; 00 empty, 01 P1, 10 P2; row 0 top.
REQ-014 SHALL have port winner_play  out  84  bits [41:0] latched win mask; bits [83:42] always 0.
REQ-015 SHALL have port theres_a_winner  out  1  high in WIN display state.
REQ-016 SHALL have port current_state  out  3  display code: 0 START, 1 PLAYER_1, 2 PLAYER_2, 3 WIN, 4 DRAW.

Function
REQ-017 SHALL implement internal FSM states IDLE, WAIT, DROP, CHECK, WIN, DRAW, plus a 1-bit turn register (0 = P1).
REQ-018 SHALL, in IDLE, output current_state=0 and ignore move_valid; on start, clear the board, move count, and win mask, set turn=P1, and go to WAIT.
REQ-019 SHALL, in WAIT, DROP, and CHECK, output current_state = 1 when turn=P1 and 2 when turn=P2.
REQ-020 SHALL assert move_ready only in WAIT; a handshake occurs when move_valid and move_ready are high in the same cycle.
REQ-021 SHALL, on a handshake with col_sel>6 or a full column (row 0 non-empty), pulse move_reject for one cycle and remain in WAIT with the turn unchanged.
REQ-022 SHALL, on a legal handshake, register the column, go to DROP, and write the turn's code into the highest-numbered empty row of that column (row 5 is the bottom) on the DROP cycle.
REQ-023 SHALL increment the move count (6 bits, 0 to 42) in the DROP cycle; the board is visible on board_state the cycle after DROP.
REQ-024 SHALL enter CHECK after DROP and hold check_req high until check_done; check_done is ignored outside CHECK.
REQ-025 SHALL, when check_done and check_win are high, latch check_mask into winner_play[41:0] and go to WIN.
REQ-026 SHALL, when check_done is high and check_win is low with move count 42, go to DRAW.
REQ-027 SHALL, when check_done is high and check_win is low with move count below 42, toggle turn and go to WAIT.
REQ-028 SHALL give win priority over draw when the 42nd move wins.
REQ-029 SHALL, in WIN, output current_state=3 and theres_a_winner=1; in DRAW, output current_state=4 and theres_a_winner=0.
REQ-030 SHALL, in WIN or DRAW, on start, perform the same clear as from IDLE and go to WAIT.
REQ-031 SHALL ignore start in WAIT, DROP, and CHECK.
REQ-032 SHALL hold board_state stable except during the DROP write and start-clear cycles.

Reset
REQ-033 SHALL, while rst_n is low at any time including mid-game, asynchronously force FSM=IDLE, turn=P1, board_state=0, winner_play=0, move count=0, timer=0, and all outputs to 0.
REQ-034 SHALL resume normal operation on the first clk edge after rst_n rises.

Configuration
REQ-035 SHALL, with macro TURN_TIMER_EN defined, implement a 32-bit timer cleared on every WAIT entry that counts each cycle spent in WAIT.
REQ-036 SHALL, with TURN_TIMER_EN defined and the timer at TURN_CYCLES-1 with no legal handshake in that cycle, force a drop into the lowest-index non-full column for the active player, following the same DROP then CHECK path.
REQ-037 SHALL, with TURN_TIMER_EN undefined, contain no timer logic and wait in WAIT indefinitely.

Verification
REQ-038 SHALL cover: reset, then start, then P1 drops into col 3 -> board_state[(5*7+3)*2 +: 2]=01, check_req asserted, on check_done with win=0, current_state=2.
REQ-039 SHALL cover: six alternating drops into col 0, then a seventh request into col 0 -> move_reject pulses once, board unchanged, turn unchanged.
REQ-040 SHALL cover: col_sel=7 -> move_reject pulses, remains in WAIT.
REQ-041 SHALL cover: check_done with win=1 and mask bits {35,36,37,38} -> current_state=3, theres_a_winner=1, winner_play[38:35]=1111, rest 0; start -> board 0, current_state=1.
REQ-042 SHALL cover: 42nd legal move with check_win=0 -> current_state=4; rst_n pulled low mid-CHECK -> all outputs 0 immediately.
REQ-043 SHALL cover, with TURN_TIMER_EN and TURN_CYCLES=16: no move for 16 cycles with col 0 full -> auto-drop into col 1, row 5, for the active player.
